// File: rtl/seg7_pkg.sv
// Shared constants and types for the multiplexed seven-segment BCD counter.
// Segment patterns are {g,f,e,d,c,b,a}, active-high.
package seg7_pkg;

    localparam int BCD_W = 4;

    typedef logic [BCD_W-1:0] bcd_digit_t;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD digit to seven-segment decoder; non-BCD codes go dark.
module seg7_decode
    import seg7_pkg::*;
(
    input  bcd_digit_t digit,
    output logic [6:0] segments
);

    always_comb begin
        segments = SEG_BLANK;
        case (digit)
            4'd0: segments = SEG_0;
            4'd1: segments = SEG_1;
            4'd2: segments = SEG_2;
            4'd3: segments = SEG_3;
            4'd4: segments = SEG_4;
            4'd5: segments = SEG_5;
            4'd6: segments = SEG_6;
            4'd7: segments = SEG_7;
            4'd8: segments = SEG_8;
            4'd9: segments = SEG_9;
            default: segments = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_bcd_counter_mux.sv
// Prescaled N-digit BCD up/down counter with time-multiplexed seven-segment output.
// Define SEG7_LZB_EN to blank leading zeros on the display.
module seg7_bcd_counter_mux
    import seg7_pkg::*;
#(
    parameter int          CNT_WIDTH     = 24,
    parameter int unsigned MAX_COUNT     = 10_000_000,
    parameter int          NUM_DIGITS    = 4,
    parameter int          MUX_DIV_WIDTH = 14
)
(
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          en,
    input  logic [7:0]                    compare_in,
    input  logic                          up_down,
    input  logic                          load,
    input  logic [BCD_W*NUM_DIGITS-1:0]   load_value,
    output logic [BCD_W*NUM_DIGITS-1:0]   count_bcd,
    output logic [6:0]                    segments,
    output logic [NUM_DIGITS-1:0]         digit_sel,
    output logic                          tick,
    output logic                          rollover
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [CNT_WIDTH-1:0]          prescaler;
    logic [CNT_WIDTH-1:0]          terminal;
    logic                          wrap_now;
    logic [BCD_W*NUM_DIGITS-1:0]   count_next;
    logic [BCD_W*NUM_DIGITS-1:0]   load_clean;
    logic                          carry_out;
    logic [MUX_DIV_WIDTH-1:0]      refresh_cnt;
    logic [IDX_W-1:0]              digit_idx;
    bcd_digit_t                    digit_mux;
    logic [6:0]                    seg_decoded;
    logic                          blank;

    // >= rather than == so lowering compare_in mid-count wraps immediately.
    always_comb begin
        terminal = (compare_in == 8'd0) ? CNT_WIDTH'(MAX_COUNT)
                                        : CNT_WIDTH'({compare_in, 10'b0});
    end

    assign wrap_now = (prescaler >= terminal);

    always_comb begin : bcd_step
        bcd_digit_t d;
        logic       c;
        count_next = count_bcd;
        c          = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            d = count_bcd[i*BCD_W +: BCD_W];
            if (c) begin
                if (up_down) begin
                    if (d == 4'd9) d = 4'd0;
                    else begin
                        d = d + 4'd1;
                        c = 1'b0;
                    end
                end else begin
                    if (d == 4'd0) d = 4'd9;
                    else begin
                        d = d - 4'd1;
                        c = 1'b0;
                    end
                end
            end
            count_next[i*BCD_W +: BCD_W] = d;
        end
        carry_out = c;
    end

    always_comb begin
        load_clean = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (load_value[i*BCD_W +: BCD_W] <= 4'd9)
                load_clean[i*BCD_W +: BCD_W] = load_value[i*BCD_W +: BCD_W];
        end
    end

    // A load also restarts the prescaler and swallows any coincident tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            prescaler <= '0;
            count_bcd <= '0;
            tick      <= 1'b0;
            rollover  <= 1'b0;
        end else begin
            tick     <= 1'b0;
            rollover <= 1'b0;
            if (load) begin
                count_bcd <= load_clean;
                prescaler <= '0;
            end else if (en) begin
                if (wrap_now) begin
                    prescaler <= '0;
                    tick      <= 1'b1;
                    count_bcd <= count_next;
                    rollover  <= carry_out;
                end else begin
                    prescaler <= prescaler + 1'b1;
                end
            end
        end
    end

    always_comb begin
        digit_mux = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (IDX_W'(i) == digit_idx)
                digit_mux = count_bcd[i*BCD_W +: BCD_W];
        end
    end

    seg7_decode u_decode (
        .digit    (digit_mux),
        .segments (seg_decoded)
    );

`ifdef SEG7_LZB_EN
    // Blank any digit above the most significant non-zero one; digit 0 always shows.
    always_comb begin : lzb
        logic [IDX_W-1:0] msd_idx;
        msd_idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (count_bcd[i*BCD_W +: BCD_W] != 4'd0)
                msd_idx = IDX_W'(i);
        end
        blank = (digit_idx > msd_idx);
    end
`else
    assign blank = 1'b0;
`endif

    // digit_sel and segments share one register stage so they always agree.
    always_ff @(posedge clk) begin
        if (reset) begin
            refresh_cnt <= '0;
            digit_idx   <= '0;
            digit_sel   <= NUM_DIGITS'(1);
            segments    <= SEG_0;
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
            if (refresh_cnt == '1)
                digit_idx <= (digit_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : digit_idx + 1'b1;
            digit_sel <= NUM_DIGITS'(1) << digit_idx;
            segments  <= blank ? SEG_BLANK : seg_decoded;
        end
    end

endmodule

// File: tb/tb_seg7_bcd_counter_mux.sv
// Scoreboard bench for seg7_bcd_counter_mux: a decimal-arithmetic model predicts every cycle.
// Expected segment values follow SEG7_LZB_EN when it is defined.
module tb_seg7_bcd_counter_mux;

    localparam int MAX_S = 4;

    logic       clk;
    logic       reset, en, up_down, load;
    logic [7:0] compare_in, load_value, count_bcd;
    logic [6:0] segments;
    logic [1:0] digit_sel;
    logic       tick, rollover;

    logic       reset_b, en_b, up_down_b, load_b;
    logic [7:0] compare_b, load_value_b, count_bcd_b;
    logic [6:0] segments_b;
    logic [1:0] digit_sel_b;
    logic       tick_b, rollover_b;

    int checks_total  = 0;
    int checks_passed = 0;

    typedef struct {
        logic [7:0] count;
        logic       tick;
        logic       roll;
        logic [1:0] sel;
        logic [6:0] seg;
    } exp_t;

    exp_t sb[$];

    int m_pre, m_val, m_ref, m_idx;

    seg7_bcd_counter_mux #(
        .CNT_WIDTH(24), .MAX_COUNT(MAX_S), .NUM_DIGITS(2), .MUX_DIV_WIDTH(2)
    ) dut (
        .clk(clk), .reset(reset), .en(en), .compare_in(compare_in),
        .up_down(up_down), .load(load), .load_value(load_value),
        .count_bcd(count_bcd), .segments(segments), .digit_sel(digit_sel),
        .tick(tick), .rollover(rollover)
    );

    seg7_bcd_counter_mux #(
        .CNT_WIDTH(24), .MAX_COUNT(1_000_000), .NUM_DIGITS(2), .MUX_DIV_WIDTH(2)
    ) dut_big (
        .clk(clk), .reset(reset_b), .en(en_b), .compare_in(compare_b),
        .up_down(up_down_b), .load(load_b), .load_value(load_value_b),
        .count_bcd(count_bcd_b), .segments(segments_b), .digit_sel(digit_sel_b),
        .tick(tick_b), .rollover(rollover_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [6:0] seg_of(input int d);
        logic [6:0] lut [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        return lut[d];
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks_total++;
        if (actual === expected) checks_passed++;
        else $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, actual, expected, $time);
    endtask

    // Drive one cycle of inputs, predict the next registered outputs, then compare.
    task automatic applyStimulus(input logic rst, input logic e, input logic ud,
                                 input logic ld, input logic [7:0] lv,
                                 input logic [7:0] cmp);
        exp_t x;
        int   term, dig, msd, lo, hi;
        reset = rst; en = e; up_down = ud; load = ld; load_value = lv; compare_in = cmp;
        x.tick = 1'b0;
        x.roll = 1'b0;
        if (rst) begin
            m_pre = 0; m_val = 0; m_ref = 0; m_idx = 0;
            x.sel = 2'b01;
            x.seg = 7'h3F;
        end else begin
            term  = (cmp == 8'd0) ? MAX_S : int'(cmp) * 1024;
            dig   = (m_idx == 0) ? m_val % 10 : m_val / 10;
            msd   = (m_val >= 10) ? 1 : 0;
            x.sel = (m_idx == 0) ? 2'b01 : 2'b10;
            x.seg = seg_of(dig);
`ifdef SEG7_LZB_EN
            if (m_idx > msd) x.seg = 7'h00;
`else
            if (msd < 0) x.seg = 7'h00;
`endif
            if (ld) begin
                lo = (lv[3:0] > 4'd9) ? 0 : int'(lv[3:0]);
                hi = (lv[7:4] > 4'd9) ? 0 : int'(lv[7:4]);
                m_val = hi * 10 + lo;
                m_pre = 0;
            end else if (e) begin
                if (m_pre >= term) begin
                    m_pre  = 0;
                    x.tick = 1'b1;
                    if (ud) begin
                        if (m_val == 99) begin m_val = 0; x.roll = 1'b1; end
                        else m_val = m_val + 1;
                    end else begin
                        if (m_val == 0) begin m_val = 99; x.roll = 1'b1; end
                        else m_val = m_val - 1;
                    end
                end else begin
                    m_pre = m_pre + 1;
                end
            end
            if (m_ref == 3) m_idx = (m_idx + 1) % 2;
            m_ref = (m_ref + 1) % 4;
        end
        x.count = {4'(m_val / 10), 4'(m_val % 10)};
        sb.push_back(x);
        @(posedge clk);
        #1;
        x = sb.pop_front();
        checkOutput("count_bcd", 32'(count_bcd), 32'(x.count));
        checkOutput("tick",      32'(tick),      32'(x.tick));
        checkOutput("rollover",  32'(rollover),  32'(x.roll));
        checkOutput("digit_sel", 32'(digit_sel), 32'(x.sel));
        checkOutput("segments",  32'(segments),  32'(x.seg));
    endtask

    initial begin
        int ticks_seen, n, changes, guard;
        logic [1:0] prev_sel;

        reset_b = 1'b1; en_b = 1'b0; up_down_b = 1'b1; load_b = 1'b0;
        compare_b = 8'd0; load_value_b = 8'd0;

        repeat (2) applyStimulus(1, 0, 1, 0, 8'h00, 0);
        repeat (20) applyStimulus(0, 1, 1, 0, 8'h00, 0);

        applyStimulus(0, 1, 1, 1, 8'h98, 0);
        repeat (10) applyStimulus(0, 1, 1, 0, 8'h00, 0);

        applyStimulus(0, 1, 0, 1, 8'h00, 0);
        repeat (5) applyStimulus(0, 1, 0, 0, 8'h00, 0);
        applyStimulus(0, 1, 0, 1, 8'h10, 0);
        repeat (5) applyStimulus(0, 1, 0, 0, 8'h00, 0);

        guard = 0;
        while (m_pre < MAX_S && guard < 10) begin
            applyStimulus(0, 1, 1, 0, 8'h00, 0);
            guard++;
        end
        applyStimulus(0, 1, 1, 1, 8'h3C, 0);
        repeat (6) applyStimulus(0, 1, 1, 0, 8'h00, 0);

        repeat (12) applyStimulus(0, 0, 1, 0, 8'h00, 0);

        applyStimulus(0, 0, 1, 1, 8'h05, 0);
        repeat (8) applyStimulus(0, 0, 1, 0, 8'h00, 0);
        applyStimulus(0, 0, 1, 1, 8'h00, 0);
        repeat (8) applyStimulus(0, 0, 1, 0, 8'h00, 0);

        repeat (7) applyStimulus(0, 1, 1, 0, 8'h00, 0);
        applyStimulus(1, 1, 1, 1, 8'h55, 0);
        repeat (3) applyStimulus(0, 1, 1, 0, 8'h00, 0);

        repeat (80) applyStimulus(0, $urandom_range(0, 3) != 0, 1'($urandom),
                                  $urandom_range(0, 15) == 0, 8'($urandom), 0);

        // Large terminal instance: lowering the terminal below the running count.
        en_b = 1'b1;
        @(posedge clk); #1;
        reset_b = 1'b0;
        ticks_seen = 0;
        repeat (1500) begin
            @(posedge clk); #1;
            if (tick_b) ticks_seen++;
        end
        checkOutput("big_no_early_tick", 32'(ticks_seen), 32'd0);
        compare_b = 8'd1;
        @(posedge clk); #1;
        checkOutput("big_wrap_next", 32'(tick_b), 32'd1);
        for (int k = 0; k < 2; k++) begin
            n = 0;
            do begin
                @(posedge clk); #1;
                n++;
            end while (!tick_b && n < 3000);
            checkOutput("big_period", 32'(n), 32'd1025);
        end
        checkOutput("big_count", 32'(count_bcd_b), 32'h03);

        en_b = 1'b0;
        prev_sel = digit_sel_b;
        changes = 0;
        repeat (16) begin
            @(posedge clk); #1;
            if (digit_sel_b != prev_sel) changes++;
            prev_sel = digit_sel_b;
        end
        checkOutput("big_hold_count", 32'(count_bcd_b), 32'h03);
        checkOutput("big_sel_rotates", 32'(changes), 32'd4);
        guard = 0;
        while (digit_sel_b != 2'b01 && guard < 8) begin
            @(posedge clk); #1;
            guard++;
        end
        checkOutput("big_sel_digit0", 32'(digit_sel_b), 32'h1);
        checkOutput("big_seg_digit0", 32'(segments_b), 32'h4F);
        checkOutput("big_rollover", 32'(rollover_b), 32'd0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
